// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, funct codes, control encodings and the D->E control bundle.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_DADDI = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LD    = 6'b110111;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SD    = 6'b111111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_NOP  = 6'b000000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_DADD = 6'b101100;
    localparam logic [5:0] F_DSUB = 6'b101110;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_DADD = 4'b1010,
        ALU_DSUB = 4'b1110
    } alucontrol_t;

    typedef enum logic [2:0] {
        RT_LW  = 3'd0,
        RT_LWU = 3'd1,
        RT_LB  = 3'd2,
        RT_LBU = 3'd3,
        RT_LD  = 3'd4
    } readtype_t;

    typedef enum logic [1:0] {
        WT_WORD  = 2'd0,
        WT_DWORD = 2'd1,
        WT_BYTE  = 2'd2
    } writetype_t;

    typedef struct packed {
        logic        regwrite;
        logic        memtoreg;
        logic        memwrite;
        writetype_t  writetype;
        readtype_t   readtype;
        logic        regdst;
        logic [1:0]  alusrc;
        alucontrol_t alucontrol;
    } ctrl_t;

endpackage

// File: rtl/maindec.sv
// maindec: combinational op/funct decode into the pipelined control bundle and D-stage controls.
module maindec
    import mips_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       branch,
    output logic       bne,
    output logic       jump,
    output logic       illegal
);

    always_comb begin
        ctrl    = '0;
        branch  = 1'b0;
        bne     = 1'b0;
        jump    = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_RTYPE: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
                case (funct)
                    F_ADD:   ctrl.alucontrol = ALU_ADD;
                    F_SUB:   ctrl.alucontrol = ALU_SUB;
                    F_AND:   ctrl.alucontrol = ALU_AND;
                    F_OR:    ctrl.alucontrol = ALU_OR;
                    F_SLT:   ctrl.alucontrol = ALU_SLT;
                    F_DADD:  ctrl.alucontrol = ALU_DADD;
                    F_DSUB:  ctrl.alucontrol = ALU_DSUB;
                    F_NOP:   ctrl = '0;
                    default: begin
                        ctrl    = '0;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_ADDI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 2'd1; ctrl.alucontrol = ALU_ADD;  end
            OP_DADDI: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 2'd1; ctrl.alucontrol = ALU_DADD; end
            OP_SLTI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 2'd1; ctrl.alucontrol = ALU_SLT;  end
            OP_ANDI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 2'd2; ctrl.alucontrol = ALU_AND;  end
            OP_ORI:   begin ctrl.regwrite = 1'b1; ctrl.alusrc = 2'd2; ctrl.alucontrol = ALU_OR;   end
            OP_LW, OP_LWU, OP_LB, OP_LBU, OP_LD: begin
                ctrl.regwrite   = 1'b1;
                ctrl.memtoreg   = 1'b1;
                ctrl.alusrc     = 2'd1;
                ctrl.alucontrol = ALU_DADD;
                ctrl.readtype   = (op == OP_LWU) ? RT_LWU :
                                  (op == OP_LB)  ? RT_LB  :
                                  (op == OP_LBU) ? RT_LBU :
                                  (op == OP_LD)  ? RT_LD  : RT_LW;
            end
            OP_SW, OP_SD, OP_SB: begin
                ctrl.memwrite   = 1'b1;
                ctrl.alusrc     = 2'd1;
                ctrl.alucontrol = ALU_DADD;
                ctrl.writetype  = (op == OP_SD) ? WT_DWORD :
                                  (op == OP_SB) ? WT_BYTE  : WT_WORD;
            end
            OP_BEQ: branch = 1'b1;
            OP_BNE: begin branch = 1'b1; bne = 1'b1; end
            OP_J:   jump = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/controller.sv
// controller: MIPS control unit; decodes in D and carries controls through D->E, E->M, M->W registers.
module controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       FlushE,
    output logic       branchD,
    output logic       bneD,
    output logic       jumpD,
    output logic       illegalD,
    output logic       regwriteE,
    output logic       regwriteM,
    output logic       regwriteW,
    output logic       memtoregE,
    output logic       memtoregM,
    output logic       memtoregW,
    output logic       regdstE,
    output logic [1:0] alusrcE,
    output logic [3:0] alucontrolE,
    output logic       memwriteM,
    output logic [1:0] writetypeM,
    output logic [2:0] readtypeM
);

    ctrl_t      w_ctrl;
    ctrl_t      r_e;
    logic       r_m_regwrite, r_m_memtoreg, r_m_memwrite;
    writetype_t r_m_writetype;
    readtype_t  r_m_readtype;
    logic       r_w_regwrite, r_w_memtoreg;

    maindec u_maindec (
        .op      (op),
        .funct   (funct),
        .ctrl    (w_ctrl),
        .branch  (branchD),
        .bne     (bneD),
        .jump    (jumpD),
        .illegal (illegalD)
    );

    // FlushE turns the instruction entering E into a bubble; reset still dominates
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_e <= '0;
        else if (FlushE)
            r_e <= '0;
        else
            r_e <= w_ctrl;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m_regwrite  <= 1'b0;
            r_m_memtoreg  <= 1'b0;
            r_m_memwrite  <= 1'b0;
            r_m_writetype <= WT_WORD;
            r_m_readtype  <= RT_LW;
            r_w_regwrite  <= 1'b0;
            r_w_memtoreg  <= 1'b0;
        end else begin
            r_m_regwrite  <= r_e.regwrite;
            r_m_memtoreg  <= r_e.memtoreg;
            r_m_memwrite  <= r_e.memwrite;
            r_m_writetype <= r_e.writetype;
            r_m_readtype  <= r_e.readtype;
            r_w_regwrite  <= r_m_regwrite;
            r_w_memtoreg  <= r_m_memtoreg;
        end
    end

    assign regwriteE   = r_e.regwrite;
    assign memtoregE   = r_e.memtoreg;
    assign regdstE     = r_e.regdst;
    assign alusrcE     = r_e.alusrc;
    assign alucontrolE = r_e.alucontrol;
    assign regwriteM   = r_m_regwrite;
    assign memtoregM   = r_m_memtoreg;
    assign memwriteM   = r_m_memwrite;
    assign writetypeM  = r_m_writetype;
    assign readtypeM   = r_m_readtype;
    assign regwriteW   = r_w_regwrite;
    assign memtoregW   = r_w_memtoreg;

endmodule

// File: tb/tb_controller.sv
// tb_controller: scoreboard bench; expected bundles queued at issue, compared per stage after each edge.
module tb_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       FlushE;
    logic       branchD, bneD, jumpD, illegalD;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoregE, memtoregM, memtoregW;
    logic       regdstE;
    logic [1:0] alusrcE;
    logic [3:0] alucontrolE;
    logic       memwriteM;
    logic [1:0] writetypeM;
    logic [2:0] readtypeM;

    int checks = 0;
    int errors = 0;
    logic [14:0] q[$];

    always #5 clk = ~clk;

    controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .FlushE(FlushE),
        .branchD(branchD), .bneD(bneD), .jumpD(jumpD), .illegalD(illegalD),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
        .memtoregE(memtoregE), .memtoregM(memtoregM), .memtoregW(memtoregW),
        .regdstE(regdstE), .alusrcE(alusrcE), .alucontrolE(alucontrolE),
        .memwriteM(memwriteM), .writetypeM(writetypeM), .readtypeM(readtypeM)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // expected bundle layout: rw mtr mw wt[2] rt[3] rd as[2] alu[4]; top nibble: ill br bne j
    function automatic logic [18:0] model(input logic [5:0] o, input logic [5:0] f);
        logic [14:0] c;
        logic [3:0]  d;
        c = '0;
        d = 4'b0000;
        case (o)
            6'b000000: case (f)
                6'b100000: c = {8'b10000000, 1'b1, 2'd0, 4'b0010};
                6'b100010: c = {8'b10000000, 1'b1, 2'd0, 4'b0110};
                6'b100100: c = {8'b10000000, 1'b1, 2'd0, 4'b0000};
                6'b100101: c = {8'b10000000, 1'b1, 2'd0, 4'b0001};
                6'b101010: c = {8'b10000000, 1'b1, 2'd0, 4'b0111};
                6'b101100: c = {8'b10000000, 1'b1, 2'd0, 4'b1010};
                6'b101110: c = {8'b10000000, 1'b1, 2'd0, 4'b1110};
                6'b000000: c = '0;
                default:   d = 4'b1000;
            endcase
            6'b001000: c = {8'b10000000, 1'b0, 2'd1, 4'b0010};
            6'b011000: c = {8'b10000000, 1'b0, 2'd1, 4'b1010};
            6'b001010: c = {8'b10000000, 1'b0, 2'd1, 4'b0111};
            6'b001100: c = {8'b10000000, 1'b0, 2'd2, 4'b0000};
            6'b001101: c = {8'b10000000, 1'b0, 2'd2, 4'b0001};
            6'b100011: c = {3'b110, 2'd0, 3'd0, 1'b0, 2'd1, 4'b1010};
            6'b100111: c = {3'b110, 2'd0, 3'd1, 1'b0, 2'd1, 4'b1010};
            6'b100000: c = {3'b110, 2'd0, 3'd2, 1'b0, 2'd1, 4'b1010};
            6'b100100: c = {3'b110, 2'd0, 3'd3, 1'b0, 2'd1, 4'b1010};
            6'b110111: c = {3'b110, 2'd0, 3'd4, 1'b0, 2'd1, 4'b1010};
            6'b101011: c = {3'b001, 2'd0, 3'd0, 1'b0, 2'd1, 4'b1010};
            6'b111111: c = {3'b001, 2'd1, 3'd0, 1'b0, 2'd1, 4'b1010};
            6'b101000: c = {3'b001, 2'd2, 3'd0, 1'b0, 2'd1, 4'b1010};
            6'b000100: d = 4'b0100;
            6'b000101: d = 4'b0110;
            6'b000010: d = 4'b0001;
            default:   d = 4'b1000;
        endcase
        return {d, c};
    endfunction

    task automatic check_stages(input string tag);
        logic [14:0] e, m, w;
        e = q[2];
        m = q[1];
        w = q[0];
        chk({tag, ".E"}, {7'b0, regwriteE, memtoregE, regdstE, alusrcE, alucontrolE},
            {7'b0, e[14], e[13], e[6], e[5:4], e[3:0]});
        chk({tag, ".M"}, {8'b0, regwriteM, memtoregM, memwriteM, writetypeM, readtypeM},
            {8'b0, m[14], m[13], m[12], m[11:10], m[9:7]});
        chk({tag, ".W"}, {14'b0, regwriteW, memtoregW}, {14'b0, w[14], w[13]});
    endtask

    task automatic empty_pipe();
        q.delete();
        repeat (3) q.push_back('0);
    endtask

    task automatic step(input string tag, input logic [5:0] o, input logic [5:0] f, input logic fl);
        logic [18:0] x;
        op = o;
        funct = f;
        FlushE = fl;
        x = model(o, f);
        #1;
        chk({tag, ".D"}, {12'b0, illegalD, branchD, bneD, jumpD}, {12'b0, x[18:15]});
        q.push_back(fl ? 15'b0 : x[14:0]);
        @(posedge clk);
        #1;
        if (q.size() > 3) void'(q.pop_front());
        check_stages(tag);
    endtask

    logic [5:0] ops[17] = '{6'b000000, 6'b001000, 6'b011000, 6'b001010, 6'b001100, 6'b001101,
                            6'b100011, 6'b100111, 6'b100000, 6'b100100, 6'b110111, 6'b101011,
                            6'b111111, 6'b101000, 6'b000100, 6'b000101, 6'b000010};
    logic [5:0] fns[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b101100,
                           6'b101110, 6'b000000};

    initial begin
        reset = 1'b1;
        op = '0;
        funct = '0;
        FlushE = 1'b0;
        #1;
        empty_pipe();
        chk("rst.D", {12'b0, illegalD, branchD, bneD, jumpD}, 16'h0);
        check_stages("rst");
        @(posedge clk);
        #1;
        check_stages("rst_hold");
        reset = 1'b0;

        step("ld", 6'b110111, 6'b000000, 1'b0);
        step("dsub", 6'b000000, 6'b101110, 1'b0);
        step("ori", 6'b001101, 6'b000000, 1'b0);
        step("bne", 6'b000101, 6'b000000, 1'b0);
        step("j", 6'b000010, 6'b000000, 1'b0);
        step("sd_flush", 6'b111111, 6'b000000, 1'b1);
        step("sd", 6'b111111, 6'b000000, 1'b0);
        step("illop", 6'b111011, 6'b000000, 1'b0);
        step("rnop", 6'b000000, 6'b000000, 1'b0);
        step("illfn", 6'b000000, 6'b111111, 1'b0);
        foreach (ops[i]) step("dir", ops[i], 6'b000000, 1'b0);
        foreach (fns[i]) step("rtype", 6'b000000, fns[i], 1'b0);
        step("lw_flush", 6'b100011, 6'b000000, 1'b1);
        step("drain0", 6'b000000, 6'b000000, 1'b0);
        step("drain1", 6'b000000, 6'b000000, 1'b0);

        // sw reaches M, then reset lands mid-cycle
        step("sw", 6'b101011, 6'b000000, 1'b0);
        step("add", 6'b000000, 6'b100000, 1'b0);
        chk("sw_in_M", {15'b0, memwriteM}, 16'h1);
        #2;
        reset = 1'b1;
        FlushE = 1'b1;
        #1;
        empty_pipe();
        chk("async_rst_mw", {15'b0, memwriteM}, 16'h0);
        check_stages("async_rst");
        @(posedge clk);
        #1;
        check_stages("rst_flush");
        reset = 1'b0;
        step("post_rst", 6'b100011, 6'b000000, 1'b0);
        step("post_rst1", 6'b000000, 6'b000000, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] o, f;
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : ops[$urandom_range(0, 16)];
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
            step("rand", o, f, ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller.md
# controller

Pipelined control unit for the 64-bit five-stage MIPS core. It decodes `op`/`funct` from the datapath's Decode stage and produces the D-stage branch/jump controls. It carries execute, memory and writeback controls through its own D→E, E→M and M→W pipeline registers, so each control arrives aligned with its instruction in the datapath. It is the companion of the datapath inside the top-level `mips` wrapper and honours the hazard unit's `FlushE`.

## Interface
- No parameters (all widths fixed by the ISA).
- `clk` in 1: the single core clock; all registers update on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `op` in 6: `instrD[31:26]`.
- `funct` in 6: `instrD[5:0]`.
- `FlushE` in 1: clears the D→E control register at the next edge.
- `branchD`, `bneD`, `jumpD` out 1 each: D-stage controls, combinational.
- `illegalD` out 1: unrecognised op/funct in D (combinational).
- `regwriteE`, `regwriteM`, `regwriteW` out 1 each.
- `memtoregE`, `memtoregM`, `memtoregW` out 1 each.
- `regdstE` out 1: 1 = rd, 0 = rt.
- `alusrcE` out 2: 0 = register, 1 = sign-ext imm, 2 = zero-ext imm.
- `alucontrolE` out 4.
- `memwriteM` out 1: data-memory write strobe.
- `writetypeM` out 2: 0 = word, 1 = doubleword, 2 = byte.
- `readtypeM` out 3: 0 = lw (sext), 1 = lwu, 2 = lb, 3 = lbu, 4 = ld.

## Operation
- Decode maps each instruction to the following controls (fields not listed are 0):
  - **R-type** (op 000000):
    - funct add 100000 → ADD; sub 100010 → SUB; and 100100 → AND; or 100101 → OR; slt 101010 → SLT; dadd 101100 → DADD; dsub 101110 → DSUB.
    - All of these set regwrite = 1 and regdst = 1.
    - funct 000000 is NOP: all controls 0, `illegalD` = 0.
  - **ALU immediates**:
    - addi 001000 → ADD, alusrc 1.
    - daddi 011000 → DADD, alusrc 1.
    - slti 001010 → SLT, alusrc 1.
    - andi 001100 → AND, alusrc 2.
    - ori 001101 → OR, alusrc 2.
    - All set regwrite = 1.
  - **Loads**: lw 100011 / lwu 100111 / lb 100000 / lbu 100100 / ld 110111.
    - regwrite = 1, memtoreg = 1, alusrc 1, DADD.
    - readtype 0/1/2/3/4 respectively.
  - **Stores**: sw 101011 / sd 111111 / sb 101000.
    - memwrite = 1, alusrc 1, DADD.
    - writetype 0/1/2 respectively.
  - **Branches and jump**:
    - beq 000100 → branch = 1.
    - bne 000101 → branch = 1, bne = 1.
    - j 000010 → jump = 1.
  - **Anything else**: all controls 0, `illegalD` = 1. The instruction therefore behaves as a NOP.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, DADD 1010, DSUB 1110.
- D→E register (fields: regwrite, memtoreg, memwrite, writetype, readtype, regdst, alusrc, alucontrol):
  - Loads the decoded bundle every edge.
  - Loads all-zero when `FlushE` = 1.
- E→M register (regwrite, memtoreg, memwrite, writetype, readtype) and M→W register (regwrite, memtoreg) load unconditionally.
- No stall input. A D stall is realised by the datapath holding `instrD`, which keeps the decode stable, together with `FlushE` inserting a bubble.

## Timing
- D outputs (`branchD`, `bneD`, `jumpD`, `illegalD`) settle combinationally in the same cycle as `op`/`funct`.
- Latency: E controls appear 1 edge after decode, M controls 2 edges after, W controls 3 edges after.
- Reset: all E/M/W outputs go to 0 immediately, without waiting for `clk`, and hold 0 while `reset` is high. D outputs follow decode, which is 0 for `op`/`funct` = 0.
- `reset` and `FlushE` asserted together: reset wins.
- `FlushE` during an edge: the bubble reaches M one edge later and W two edges later. The instruction being flushed never asserts `memwriteM` or `regwriteW`.
- Reset deasserted mid-program: the pipeline restarts empty; no stale control survives.

## Structure
- Package `mips_pkg` holds:
  - opcode and funct constants;
  - `alucontrol_t` (4-bit enum), `readtype_t` (3-bit), `writetype_t` (2-bit);
  - packed struct `ctrl_t` for the D→E bundle.
- Sub-module `maindec`: purely combinational op/funct → `ctrl_t` plus D signals plus `illegalD`.
- `controller` instantiates `maindec` and three async-reset pipeline registers; the D→E register has a synchronous clear.

## Test plan
- Reset mid-stream with a `sw` in M → `memwriteM` drops to 0 immediately; all E/M/W outputs 0 until the first post-reset edge.
- ld (op 110111) in D → after 1 edge `alucontrolE` = 1010, `alusrcE` = 1; after 2 edges `readtypeM` = 4; after 3 edges `regwriteW` = 1, `memtoregW` = 1.
- dsub (op 000000, funct 101110) → `regdstE` = 1, `alucontrolE` = 1110; ori → `alusrcE` = 2, `alucontrolE` = 0001.
- bne in D → `branchD` = 1, `bneD` = 1 same cycle; j → `jumpD` = 1; E/M/W writes stay 0 for both.
- sd in D with `FlushE` = 1 at that edge → `memwriteM` = 0 two edges later. Without the flush → `memwriteM` = 1, `writetypeM` = 1.
- op 111011 → `illegalD` = 1 and all pipelined controls 0; funct 000000 R-type → `illegalD` = 0, all 0.
